// File: rtl/mc_controller_hs_if.sv
// mc_controller_hs_if -- handshake bundle between the multicycle control FSM,
// the unified memory port and the optional multiply/divide unit.
//
// Handshake semantics (memory): MemReq is the valid. Once raised it stays high,
// together with MemWrite and the address select, until a cycle where MemReady
// is high; that cycle completes the transfer. MemReady is only meaningful while
// MemReq is high.
// Handshake semantics (MDU): MduStart is a one-cycle launch pulse. MduDone
// signals a valid result and may arrive in the same cycle as MduStart.
//
// Signals:
//   MemReq   controller -> memory  request valid
//   MemWrite controller -> memory  write qualifier (only with MemReq)
//   MemReady memory -> controller  request completes this cycle
//   MduStart controller -> MDU     launch pulse
//   MduDone  MDU -> controller     result valid
interface mc_controller_hs_if;
  logic MemReq;
  logic MemWrite;
  logic MemReady;
  logic MduStart;
  logic MduDone;

  modport master (
    output MemReq,
    output MemWrite,
    output MduStart,
    input  MemReady,
    input  MduDone
  );

  modport slave (
    input  MemReq,
    input  MemWrite,
    input  MduStart,
    output MemReady,
    output MduDone
  );
endinterface

// File: rtl/mc_controller_hs.sv
// mc_controller_hs -- multicycle RV32I control FSM with a req/ready memory
// handshake, wait-state timeout, optional multi-cycle MDU path and an
// absorbing trap state.
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset (state FETCH)
//   bus (master)      MemReq/MemWrite/MemReady, MduStart/MduDone
//   op, funct3, funct7b5, funct7b0   instruction fields from the IR
//   Zero, ALUResultLSB               ALU flags used by branches
//   AdrSrc, IRWrite, PCWrite, PCSrc, RegWrite   datapath enables/selects
//   ALUSrcA, ALUSrcB, ImmSrc, ResultSrc, ALUControl   datapath selects
//   Trap, TrapCause   core halted and why (01 illegal, 10 memory timeout)
//   state_dbg_o       current FSM state encoding
//
// ALUControl encoding: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor,
// 0101 slt, 0110 sltu, 0111 sll, 1000 srl, 1001 sra.
module mc_controller_hs #(
  parameter bit ENABLE_MDU  = 1'b0,
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  mc_controller_hs_if.master   bus,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 funct7b0,
  input  logic                 Zero,
  input  logic                 ALUResultLSB,
  output logic                 AdrSrc,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic                 PCSrc,
  output logic                 RegWrite,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [2:0]           ImmSrc,
  output logic [2:0]           ResultSrc,
  output logic [3:0]           ALUControl,
  output logic                 Trap,
  output logic [1:0]           TrapCause,
  output logic [3:0]           state_dbg_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_EXECU    = 4'd8,
    S_JAL      = 4'd9,
    S_ALUWB    = 4'd10,
    S_BRANCH   = 4'd11,
    S_MDUEXEC  = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BR    = 7'b1100011;

  // Timeout fires in the cycle the counter would reach MEM_TIMEOUT, so a
  // request sees exactly MEM_TIMEOUT wait cycles before the trap.
  localparam bit            TO_EN    = (MEM_TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TO_EN ? MEM_TIMEOUT - 1 : 0);

  state_t          state_q;
  logic [TO_W-1:0] to_q;
  logic [1:0]      cause_q;
  logic            mdu_first_q;

  logic mem_state;
  logic mem_timeout;
  logic mdu_op;

  assign mem_state   = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                       (state_q == S_MEMWRITE);
  assign mem_timeout = TO_EN && mem_state && !bus.MemReady && (to_q == TO_LIMIT);
  assign mdu_op      = (op == OP_R) && funct7b0;

  // Single FSM process: state, wait-state counter, trap cause, MDU first-cycle flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_FETCH;
      to_q        <= '0;
      cause_q     <= 2'b00;
      mdu_first_q <= 1'b0;
    end else begin
      // Counts consecutive wait cycles of the current request; anything other
      // than a waiting memory state clears it, which covers entry and completion.
      to_q        <= (mem_state && !bus.MemReady) ? to_q + TO_W'(1) : '0;
      mdu_first_q <= 1'b0;
      if (mem_timeout) begin
        state_q <= S_TRAP;
        cause_q <= 2'b10;
      end else begin
        case (state_q)
          S_FETCH:    if (bus.MemReady) state_q <= S_DECODE;
          S_DECODE: begin
            case (op)
              OP_LOAD, OP_STORE: state_q <= S_MEMADR;
              OP_R: begin
                if (!funct7b0) begin
                  state_q <= S_EXECR;
                end else if (ENABLE_MDU) begin
                  state_q     <= S_MDUEXEC;
                  mdu_first_q <= 1'b1;
                end else begin
                  state_q <= S_TRAP;
                  cause_q <= 2'b01;
                end
              end
              OP_IMM, OP_JALR:   state_q <= S_EXECI;
              OP_LUI, OP_AUIPC:  state_q <= S_EXECU;
              OP_JAL:            state_q <= S_JAL;
              OP_BR:             state_q <= S_BRANCH;
              default: begin
                state_q <= S_TRAP;
                cause_q <= 2'b01;
              end
            endcase
          end
          S_MEMADR:   state_q <= (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
          S_MEMREAD:  if (bus.MemReady) state_q <= S_MEMWB;
          S_MEMWB:    state_q <= S_FETCH;
          S_MEMWRITE: if (bus.MemReady) state_q <= S_FETCH;
          S_EXECR, S_EXECI, S_EXECU, S_JAL: state_q <= S_ALUWB;
          S_ALUWB:    state_q <= S_FETCH;
          S_BRANCH:   state_q <= S_FETCH;
          S_MDUEXEC:  if (bus.MduDone) state_q <= S_ALUWB;
          S_TRAP:     state_q <= S_TRAP;
          default:    state_q <= S_FETCH;
        endcase
      end
    end
  end

  logic [1:0] alu_op;
  logic       taken;
  logic       mem_req, mem_write, mdu_start;

  always_comb begin
    case (funct3)
      3'b000:  taken = Zero;
      3'b001:  taken = !Zero;
      3'b100,
      3'b110:  taken = ALUResultLSB;
      3'b101,
      3'b111:  taken = !ALUResultLSB;
      default: taken = 1'b0;
    endcase
  end

  // Output decode from the registered state; only FETCH/BRANCH look at inputs.
  always_comb begin
    mem_req   = 1'b0;
    mem_write = 1'b0;
    mdu_start = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    PCSrc     = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ImmSrc    = 3'b000;
    ResultSrc = 3'b000;
    alu_op    = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 3'b010;
        IRWrite   = bus.MemReady;
        PCWrite   = bus.MemReady;
      end
      S_DECODE: begin
        ALUSrcA = ((op == OP_JAL) || (op == OP_BR)) ? 2'b01 : 2'b10;
        ALUSrcB = 2'b01;
        case (op)
          OP_STORE:         ImmSrc = 3'b001;
          OP_BR:            ImmSrc = 3'b010;
          OP_LUI, OP_AUIPC: ImmSrc = 3'b011;
          OP_JAL:           ImmSrc = 3'b100;
          default:          ImmSrc = 3'b000;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = (op == OP_STORE) ? 3'b001 : 3'b000;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
      end
      S_MEMWB: begin
        RegWrite  = 1'b1;
        ResultSrc = 3'b001;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        AdrSrc    = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b10;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        // Shift-immediates take the 5-bit shamt form.
        ImmSrc  = (funct3[1:0] == 2'b01) ? 3'b101 : 3'b000;
        alu_op  = 2'b10;
      end
      S_EXECU: begin
        ALUSrcA = (op == OP_LUI) ? 2'b11 : 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = 3'b011;
      end
      S_JAL: begin
        PCWrite = 1'b1;
        PCSrc   = 1'b1;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        if ((op == OP_JAL) || (op == OP_JALR)) ResultSrc = 3'b011;
        else if (ENABLE_MDU && mdu_op)         ResultSrc = 3'b100;
        else                                   ResultSrc = 3'b000;
      end
      S_BRANCH: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b11;
        PCWrite = taken;
        PCSrc   = taken;
      end
      S_MDUEXEC: begin
        mdu_start = mdu_first_q;
      end
      default: ;
    endcase
  end

  // ALU decoder: 00 add, 01 sub, 10 from funct3/funct7, 11 branch compare.
  always_comb begin
    ALUControl = 4'b0000;
    case (alu_op)
      2'b01: ALUControl = 4'b0001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] && funct7b5) ? 4'b0001 : 4'b0000;
          3'b001:  ALUControl = 4'b0111;
          3'b010:  ALUControl = 4'b0101;
          3'b011:  ALUControl = 4'b0110;
          3'b100:  ALUControl = 4'b0100;
          3'b101:  ALUControl = funct7b5 ? 4'b1001 : 4'b1000;
          3'b110:  ALUControl = 4'b0011;
          default: ALUControl = 4'b0010;
        endcase
      end
      2'b11: begin
        case (funct3[2:1])
          2'b10:   ALUControl = 4'b0101;
          2'b11:   ALUControl = 4'b0110;
          default: ALUControl = 4'b0001;
        endcase
      end
      default: ALUControl = 4'b0000;
    endcase
  end

  assign bus.MemReq   = mem_req;
  assign bus.MemWrite = mem_write;
  assign bus.MduStart = mdu_start;
  assign Trap         = (state_q == S_TRAP);
  assign TrapCause    = cause_q;
  assign state_dbg_o  = state_q;

endmodule

// File: tb/tb_mc_controller_hs.sv
// Directed bench for mc_controller_hs. Two instances share every input:
// u_dut0 (no MDU, MEM_TIMEOUT=4) and u_dut1 (MDU enabled, MEM_TIMEOUT=16).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_mc_controller_hs;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_JAL      = 4'd9;
  localparam logic [3:0] S_ALUWB    = 4'd10;
  localparam logic [3:0] S_BRANCH   = 4'd11;
  localparam logic [3:0] S_MDUEXEC  = 4'd12;
  localparam logic [3:0] S_TRAP     = 4'd13;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, funct7b0, zero, lsb;
  logic       mem_ready, mdu_done;

  mc_controller_hs_if bus0 ();
  mc_controller_hs_if bus1 ();
  assign bus0.MemReady = mem_ready;
  assign bus0.MduDone  = mdu_done;
  assign bus1.MemReady = mem_ready;
  assign bus1.MduDone  = mdu_done;

  logic       adr0, irw0, pcw0, pcs0, rw0, trap0;
  logic [1:0] asa0, asb0, cause0;
  logic [2:0] imm0, res0;
  logic [3:0] aluc0, st0;
  logic       adr1, irw1, pcw1, pcs1, rw1, trap1;
  logic [1:0] asa1, asb1, cause1;
  logic [2:0] imm1, res1;
  logic [3:0] aluc1, st1;

  mc_controller_hs #(.ENABLE_MDU(1'b0), .MEM_TIMEOUT(4), .TO_W(3)) u_dut0 (
    .clk(clk), .reset(rst), .bus(bus0),
    .op(op), .funct3(funct3), .funct7b5(funct7b5), .funct7b0(funct7b0),
    .Zero(zero), .ALUResultLSB(lsb),
    .AdrSrc(adr0), .IRWrite(irw0), .PCWrite(pcw0), .PCSrc(pcs0), .RegWrite(rw0),
    .ALUSrcA(asa0), .ALUSrcB(asb0), .ImmSrc(imm0), .ResultSrc(res0),
    .ALUControl(aluc0), .Trap(trap0), .TrapCause(cause0), .state_dbg_o(st0)
  );

  mc_controller_hs #(.ENABLE_MDU(1'b1), .MEM_TIMEOUT(16), .TO_W(5)) u_dut1 (
    .clk(clk), .reset(rst), .bus(bus1),
    .op(op), .funct3(funct3), .funct7b5(funct7b5), .funct7b0(funct7b0),
    .Zero(zero), .ALUResultLSB(lsb),
    .AdrSrc(adr1), .IRWrite(irw1), .PCWrite(pcw1), .PCSrc(pcs1), .RegWrite(rw1),
    .ALUSrcA(asa1), .ALUSrcB(asb1), .ImmSrc(imm1), .ResultSrc(res1),
    .ALUControl(aluc1), .Trap(trap1), .TrapCause(cause1), .state_dbg_o(st1)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic next_cycle(input logic ready, input logic done);
    @(posedge clk);
    @(negedge clk);
    mem_ready = ready;
    mdu_done  = done;
    #1;
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3,
                           input logic f5, input logic f0);
    op = o; funct3 = f3; funct7b5 = f5; funct7b0 = f0;
    #0;
  endtask

  // Entered in FETCH with MemReady already high; leaves the DUTs in DECODE.
  task automatic fetch_decode(input string tag);
    check({tag, "_fetch_st"}, st1, S_FETCH);
    check({tag, "_fetch_irw"}, irw1, 1'b1);
    next_cycle(1'b0, 1'b0);
    check({tag, "_decode_st"}, st1, S_DECODE);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mem_ready = 1'b0; mdu_done = 1'b0;
    zero = 1'b0; lsb = 1'b0;
    set_instr(7'b0110011, 3'b000, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    // Reset state
    check("rst_state", st1, S_FETCH);
    check("rst_memreq", bus1.MemReq, 1'b1);
    check("rst_trap", trap1, 1'b0);
    check("rst_alusrcb", asb1, 2'b10);
    check("rst_resultsrc", res1, 3'b010);
    check("rst_irwrite", irw1, 1'b0);

    // add with three fetch wait states
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("add_wait_st", st1, S_FETCH);
      check("add_wait_irw", irw1, 1'b0);
      check("add_wait_req", bus1.MemReq, 1'b1);
      next_cycle(i == 2, 1'b0);
    end
    check("add_pcw", pcw1, 1'b1);
    fetch_decode("add");
    check("add_dec_irw", irw1, 1'b0);
    next_cycle(1'b0, 1'b0);
    check("add_execr_st", st1, S_EXECR);
    check("add_execr_aluc", aluc1, 4'b0000);
    check("add_execr_srca", asa1, 2'b10);
    check("add_execr_rw", rw1, 1'b0);
    next_cycle(1'b0, 1'b0);
    check("add_aluwb_st", st1, S_ALUWB);
    check("add_aluwb_rw", rw1, 1'b1);
    check("add_aluwb_res", res1, 3'b000);
    next_cycle(1'b1, 1'b0);

    // lw with zero-wait memory read: 5 cycles
    set_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
    fetch_decode("lw");
    next_cycle(1'b0, 1'b0);
    check("lw_memadr_st", st1, S_MEMADR);
    check("lw_memadr_srcb", asb1, 2'b01);
    next_cycle(1'b1, 1'b0);
    check("lw_memread_st", st1, S_MEMREAD);
    check("lw_memread_adr", adr1, 1'b1);
    check("lw_memread_wr", bus1.MemWrite, 1'b0);
    next_cycle(1'b0, 1'b0);
    check("lw_memwb_st", st1, S_MEMWB);
    check("lw_memwb_rw", rw1, 1'b1);
    check("lw_memwb_res", res1, 3'b001);
    next_cycle(1'b1, 1'b0);
    check("lw_back_fetch", st1, S_FETCH);

    // beq taken
    set_instr(7'b1100011, 3'b000, 1'b0, 1'b0);
    zero = 1'b1;
    fetch_decode("beq");
    check("beq_dec_srca", asa1, 2'b01);
    check("beq_dec_imm", imm1, 3'b010);
    next_cycle(1'b0, 1'b0);
    check("beq_br_st", st1, S_BRANCH);
    check("beq_br_pcw", pcw1, 1'b1);
    check("beq_br_pcs", pcs1, 1'b1);
    check("beq_br_aluc", aluc1, 4'b0001);
    next_cycle(1'b1, 1'b0);
    check("beq_back_fetch", st1, S_FETCH);

    // bge with LSB=1: not taken
    set_instr(7'b1100011, 3'b101, 1'b0, 1'b0);
    zero = 1'b0; lsb = 1'b1;
    fetch_decode("bge");
    next_cycle(1'b0, 1'b0);
    check("bge_br_st", st1, S_BRANCH);
    check("bge_br_pcw", pcw1, 1'b0);
    check("bge_br_aluc", aluc1, 4'b0101);
    next_cycle(1'b1, 1'b0);
    check("bge_back_fetch", st1, S_FETCH);
    lsb = 1'b0;

    // jal
    set_instr(7'b1101111, 3'b000, 1'b0, 1'b0);
    fetch_decode("jal");
    check("jal_dec_imm", imm1, 3'b100);
    next_cycle(1'b0, 1'b0);
    check("jal_st", st1, S_JAL);
    check("jal_pcw", pcw1, 1'b1);
    check("jal_pcs", pcs1, 1'b1);
    next_cycle(1'b0, 1'b0);
    check("jal_aluwb_res", res1, 3'b011);
    next_cycle(1'b1, 1'b0);

    // sw: MemReady arrives on the 4th wait cycle, exactly at the limit -> no trap
    set_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
    fetch_decode("sw_edge");
    next_cycle(1'b0, 1'b0);
    check("sw_edge_imm", imm1, 3'b001);
    for (int i = 1; i <= 4; i++) begin
      next_cycle(i == 4, 1'b0);
      check("sw_edge_st0", st0, S_MEMWRITE);
      check("sw_edge_wr0", bus0.MemWrite, 1'b1);
    end
    next_cycle(1'b1, 1'b0);
    check("sw_edge_fetch0", st0, S_FETCH);
    check("sw_edge_trap0", trap0, 1'b0);

    // sw: MemReady never comes -> dut0 traps after 4 waits
    fetch_decode("sw_to");
    next_cycle(1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      next_cycle(1'b0, 1'b0);
      check("sw_to_wait_st0", st0, S_MEMWRITE);
      check("sw_to_wait_req0", bus0.MemReq, 1'b1);
    end
    next_cycle(1'b0, 1'b0);
    check("sw_to_st0", st0, S_TRAP);
    check("sw_to_trap0", trap0, 1'b1);
    check("sw_to_cause0", cause0, 2'b10);
    check("sw_to_req0", bus0.MemReq, 1'b0);
    check("sw_to_st1", st1, S_MEMWRITE);
    check("sw_to_req1", bus1.MemReq, 1'b1);
    next_cycle(1'b1, 1'b0);
    check("sw_to_hold0", st0, S_TRAP);
    check("sw_to_hold_req0", bus0.MemReq, 1'b0);
    check("sw_to_hold_cause0", cause0, 2'b10);
    next_cycle(1'b1, 1'b0);
    check("sw_to_fetch1", st1, S_FETCH);
    rst = 1'b1;
    #1;
    check("sw_to_rst_st0", st0, S_FETCH);
    check("sw_to_rst_trap0", trap0, 1'b0);
    check("sw_to_rst_cause0", cause0, 2'b00);
    check("sw_to_rst_req0", bus0.MemReq, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // illegal opcode
    set_instr(7'b1111111, 3'b000, 1'b0, 1'b0);
    fetch_decode("ill");
    next_cycle(1'b0, 1'b0);
    check("ill_st", st1, S_TRAP);
    check("ill_cause", cause1, 2'b01);
    check("ill_req", bus1.MemReq, 1'b0);
    next_cycle(1'b1, 1'b0);
    check("ill_hold_st", st1, S_TRAP);
    check("ill_hold_pcw", pcw1, 1'b0);
    rst = 1'b1;
    #1;
    check("ill_rst_st", st1, S_FETCH);
    check("ill_rst_trap", trap1, 1'b0);
    check("ill_rst_req", bus1.MemReq, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // mul: MduDone 7 cycles after start on dut1; illegal on dut0
    set_instr(7'b0110011, 3'b000, 1'b0, 1'b1);
    fetch_decode("mul");
    next_cycle(1'b0, 1'b0);
    check("mul_st1", st1, S_MDUEXEC);
    check("mul_start1", bus1.MduStart, 1'b1);
    check("mul_st0", st0, S_TRAP);
    check("mul_cause0", cause0, 2'b01);
    for (int k = 1; k <= 7; k++) begin
      next_cycle(1'b0, k == 7);
      check("mul_wait_st1", st1, S_MDUEXEC);
      check("mul_wait_start1", bus1.MduStart, 1'b0);
    end
    next_cycle(1'b0, 1'b0);
    check("mul_aluwb_st1", st1, S_ALUWB);
    check("mul_aluwb_rw1", rw1, 1'b1);
    check("mul_aluwb_res1", res1, 3'b100);
    next_cycle(1'b1, 1'b0);

    // mul with MduDone in the start cycle
    fetch_decode("mul0");
    next_cycle(1'b0, 1'b1);
    check("mul0_start1", bus1.MduStart, 1'b1);
    next_cycle(1'b0, 1'b0);
    check("mul0_aluwb_st1", st1, S_ALUWB);
    check("mul0_aluwb_res1", res1, 3'b100);
    next_cycle(1'b1, 1'b0);
    check("mul0_back_fetch", st1, S_FETCH);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
